// File: rtl/mcpu_boot_ram_if.sv
// mcpu_boot_ram_if
//   Bundles the loader byte handshake and the CPU address/strobe lines
//   that connect to mcpu_boot_ram. The bidirectional CPU data bus is a
//   plain inout port on the RAM, so its tristate driver stays a single
//   net.
// Signals
//   ld_data    loader byte (master -> slave)
//   ld_valid   loader byte valid (master -> slave)
//   ld_ready   RAM accepts a loader byte (slave -> master)
//   cpu_adress CPU word address (master -> slave)
//   cpu_oe     CPU read strobe, active-low (master -> slave)
//   cpu_we     CPU write strobe, active-low (master -> slave)
// Modports
//   master  loader / CPU side
//   slave   mcpu_boot_ram side
interface mcpu_boot_ram_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] ld_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] cpu_adress;
  logic              cpu_oe;
  logic              cpu_we;

  modport master (
    output ld_data,
    output ld_valid,
    input  ld_ready,
    output cpu_adress,
    output cpu_oe,
    output cpu_we
  );

  modport slave (
    input  ld_data,
    input  ld_valid,
    output ld_ready,
    input  cpu_adress,
    input  cpu_oe,
    input  cpu_we
  );
endinterface

// File: rtl/mcpu_boot_ram.sv
// mcpu_boot_ram
//   Program RAM plus boot loader sitting on the mcpu bus. After reset the
//   CPU is held in reset while a byte stream fills every word starting at
//   address 0; the CPU is then released and may read and write the RAM.
//   The top word is mirrored to io_out on every CPU write to it.
// Ports
//   clk       single clock, rising edge
//   rst       asynchronous reset, active-low
//   bus       loader handshake and CPU address/strobes (slave modport)
//   cpu_data  CPU data bus; driven only during a CPU read in RUN
//   cpu_rst   registered active-low reset to the CPU
//   io_out    last value the CPU wrote to word DEPTH-1
//   done      load complete, CPU running
//   err       sticky error flag
// Configuration
//   MCPU_BOOT_CHKSUM_EN  when defined, one checksum byte follows the image;
//                        the 8-bit wrap-around sum of image plus checksum
//                        must be zero or the block locks in ERR until rst.
module mcpu_boot_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  mcpu_boot_ram_if.slave    bus,
  inout  wire  [DATA_W-1:0] cpu_data,
  output logic              cpu_rst,
  output logic [DATA_W-1:0] io_out,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_CHK,
    ST_RUN,
    ST_ERR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ld_cnt;
  logic [ADDR_W-1:0] ld_cnt_nxt;
  logic              ld_ready_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              ld_fire;
  logic              in_run;
  logic              rd_en;
  logic              wr_en;
  logic              conflict;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              err_set;
  logic              io_we;

`ifdef MCPU_BOOT_CHKSUM_EN
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] sum_nxt;
  logic [DATA_W-1:0] chk_total;
`endif

  assign ld_fire      = bus.ld_valid && ld_ready_q;
  assign bus.ld_ready = ld_ready_q;

  // Strobes only mean something while the CPU is out of reset. Both strobes
  // low together is a conflict: neither a read nor a write happens.
  assign in_run   = (state == ST_RUN);
  assign rd_en    = in_run && !bus.cpu_oe &&  bus.cpu_we;
  assign wr_en    = in_run &&  bus.cpu_oe && !bus.cpu_we;
  assign conflict = in_run && !bus.cpu_oe && !bus.cpu_we;

  // Combinational read path onto the shared bus.
  assign cpu_data = rd_en ? mem[bus.cpu_adress] : {DATA_W{1'bz}};

`ifdef MCPU_BOOT_CHKSUM_EN
  assign chk_total = sum + bus.ld_data;
`endif

  always_comb begin
    state_nxt  = state;
    ld_cnt_nxt = ld_cnt;
    mem_we     = 1'b0;
    mem_addr   = ld_cnt;
    mem_wdata  = bus.ld_data;
    err_set    = 1'b0;
    io_we      = 1'b0;
`ifdef MCPU_BOOT_CHKSUM_EN
    sum_nxt    = sum;
`endif

    unique case (state)
      ST_LOAD: begin
        if (ld_fire) begin
          mem_we     = 1'b1;
          ld_cnt_nxt = ld_cnt + ADDR_W'(1);
`ifdef MCPU_BOOT_CHKSUM_EN
          sum_nxt    = sum + bus.ld_data;
`endif
          if (ld_cnt == LAST_ADDR) begin
`ifdef MCPU_BOOT_CHKSUM_EN
            state_nxt = ST_CHK;
`else
            state_nxt = ST_RUN;
`endif
          end
        end
      end

`ifdef MCPU_BOOT_CHKSUM_EN
      // The checksum byte is compared, never stored.
      ST_CHK: begin
        if (ld_fire) begin
          if (chk_total == '0) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_ERR;
            err_set   = 1'b1;
          end
        end
      end
`endif

      ST_RUN: begin
        if (wr_en) begin
          mem_we    = 1'b1;
          mem_addr  = bus.cpu_adress;
          mem_wdata = cpu_data;
          io_we     = (bus.cpu_adress == LAST_ADDR);
        end
        if (conflict) begin
          err_set = 1'b1;
        end
      end

      default: begin
      end
    endcase
  end

  // Handshake and CPU control outputs are registered from the next state so
  // they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_LOAD;
      ld_cnt     <= '0;
      ld_ready_q <= 1'b0;
      cpu_rst    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      io_out     <= '0;
`ifdef MCPU_BOOT_CHKSUM_EN
      sum        <= '0;
`endif
    end else begin
      state      <= state_nxt;
      ld_cnt     <= ld_cnt_nxt;
      ld_ready_q <= (state_nxt == ST_LOAD) || (state_nxt == ST_CHK);
      cpu_rst    <= (state_nxt == ST_RUN);
      done       <= (state_nxt == ST_RUN);
      if (err_set) begin
        err <= 1'b1;
      end
      if (io_we) begin
        io_out <= cpu_data;
      end
`ifdef MCPU_BOOT_CHKSUM_EN
      sum        <= sum_nxt;
`endif
    end
  end

  // RAM array has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_mcpu_boot_ram.sv
// tb_mcpu_boot_ram
//   Directed plus randomized bench for mcpu_boot_ram. A plain array model
//   of the RAM contents, the io mirror and the error flag supplies every
//   expected value. The data bus is pulled high, so a released bus reads
//   as all ones; no stored word is ever 8'hFF so a stray drive shows up.
module tb_mcpu_boot_ram;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  tri1 [DATA_W-1:0]  cpu_data;
  logic              drvEn  = 1'b0;
  logic [DATA_W-1:0] drvVal = '0;
  logic              cpu_rst;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] io_out;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] img   [DEPTH];
  logic [DATA_W-1:0] modelIo  = '0;
  logic              modelErr = 1'b0;

  mcpu_boot_ram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  assign cpu_data = drvEn ? drvVal : {DATA_W{1'bz}};

  mcpu_boot_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cpu_data(cpu_data),
    .cpu_rst (cpu_rst),
    .io_out  (io_out),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic oe,
                               input logic we, input logic [5:0] a,
                               input logic den, input logic [7:0] dv);
    bus.ld_valid   = v;
    bus.ld_data    = d;
    bus.cpu_oe     = oe;
    bus.cpu_we     = we;
    bus.cpu_adress = a;
    drvEn          = den;
    drvVal         = dv;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 6'd0, 1'b0, 8'h00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readCheck(input string tag, input int a, input logic [7:0] exp);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 6'(a), 1'b0, 8'h00);
    #1;
    checkOutput(tag, cpu_data, exp);
    idle();
    tick();
  endtask

  // Streams img[0..count-1]; optional two-cycle valid gap after every 8th byte.
  task automatic loadImage(input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      applyStimulus(1'b1, img[i], 1'b1, 1'b1, 6'd0, 1'b0, 8'h00);
      if (i == 0) checkOutput("ld_ready_first", 8'(bus.ld_ready), 8'd1);
      if (i == DEPTH - 1) checkOutput("cpu_rst_before_last", 8'(cpu_rst), 8'd0);
      tick();
      model[i] = img[i];
      if (i == DEPTH - 1) begin
`ifdef MCPU_BOOT_CHKSUM_EN
        checkOutput("chk_ld_ready", 8'(bus.ld_ready), 8'd1);
        checkOutput("chk_done", 8'(done), 8'd0);
`else
        checkOutput("done_after_last", 8'(done), 8'd1);
        checkOutput("cpu_rst_after_last", 8'(cpu_rst), 8'd1);
        checkOutput("ld_ready_after_last", 8'(bus.ld_ready), 8'd0);
`endif
      end
      if (gaps && (i % 8) == 7) begin
        idle();
        tick();
        tick();
      end
    end
    idle();
  endtask

`ifdef MCPU_BOOT_CHKSUM_EN
  task automatic sendChecksum(input bit good);
    int total;
    logic [7:0] ck;
    total = 0;
    for (int i = 0; i < DEPTH; i++) total += int'(model[i]);
    ck = 8'((256 - (total % 256)) % 256);
    if (!good) ck = ck + 8'h60;
    applyStimulus(1'b1, ck, 1'b1, 1'b1, 6'd0, 1'b0, 8'h00);
    tick();
    idle();
    if (good) begin
      checkOutput("chk_good_done", 8'(done), 8'd1);
      checkOutput("chk_good_cpu_rst", 8'(cpu_rst), 8'd1);
      checkOutput("chk_good_err", 8'(err), 8'(modelErr));
    end else begin
      modelErr = 1'b1;
      checkOutput("chk_bad_err", 8'(err), 8'd1);
      checkOutput("chk_bad_cpu_rst", 8'(cpu_rst), 8'd0);
      checkOutput("chk_bad_done", 8'(done), 8'd0);
    end
    checkOutput("chk_ld_ready_low", 8'(bus.ld_ready), 8'd0);
  endtask
`endif

  initial begin
    int a;
    logic [7:0] d;

    // Reset held for three clocks
    idle();
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("rst_ld_ready", 8'(bus.ld_ready), 8'd0);
    checkOutput("rst_cpu_rst", 8'(cpu_rst), 8'd0);
    checkOutput("rst_io_out", io_out, 8'h00);
    checkOutput("rst_done", 8'(done), 8'd0);
    checkOutput("rst_err", 8'(err), 8'd0);
    checkOutput("rst_bus_released", cpu_data, 8'hFF);
    rst = 1'b1;
    #1;
    checkOutput("release_ld_ready_low", 8'(bus.ld_ready), 8'd0);
    tick();
    checkOutput("release_ld_ready_high", 8'(bus.ld_ready), 8'd1);

    // Ramp image with valid gaps
    for (int i = 0; i < DEPTH; i++) img[i] = 8'(i);
    loadImage(DEPTH, 1'b1);
`ifdef MCPU_BOOT_CHKSUM_EN
    sendChecksum(1'b1);
`endif
    // Extra byte must be ignored
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b1, 6'd0, 1'b0, 8'h00);
    tick();
    idle();
    checkOutput("extra_ld_ready", 8'(bus.ld_ready), 8'd0);
    readCheck("extra_not_written", 0, model[0]);

    // Read of word 5, then bus release
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 6'd5, 1'b0, 8'h00);
    #1;
    checkOutput("read5", cpu_data, 8'h05);
    idle();
    #1;
    checkOutput("read5_release", cpu_data, 8'hFF);
    tick();

    // Write to the io word
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 6'd63, 1'b1, 8'hA5);
    #1;
    checkOutput("io_before_edge", io_out, 8'h00);
    tick();
    idle();
    model[63] = 8'hA5;
    modelIo   = 8'hA5;
    checkOutput("io_after_write", io_out, modelIo);
    readCheck("read63", 63, model[63]);

    // Strobe conflict at word 10
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 6'd10, 1'b0, 8'h00);
    #1;
    checkOutput("conflict_no_drive", cpu_data, 8'hFF);
    checkOutput("conflict_err_before", 8'(err), 8'd0);
    tick();
    idle();
    modelErr = 1'b1;
    checkOutput("conflict_err", 8'(err), 8'(modelErr));
    tick();
    checkOutput("conflict_err_sticky", 8'(err), 8'(modelErr));
    checkOutput("conflict_still_run", 8'(done), 8'd1);
    readCheck("conflict_mem10", 10, model[10]);

    // Random CPU traffic against the array model
    for (int k = 0; k < 60; k++) begin
      a = ($urandom_range(0, 3) == 0) ? 63 : int'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom_range(0, 254));
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 6'(a), 1'b1, d);
        tick();
        idle();
        model[a] = d;
        if (a == DEPTH - 1) modelIo = d;
        checkOutput("rand_io_out", io_out, modelIo);
      end else begin
        readCheck("rand_read", a, model[a]);
      end
    end
    checkOutput("rand_err", 8'(err), 8'(modelErr));

    // Asynchronous reset, partial load, reset again, full reload
    rst = 1'b0;
    #1;
    modelErr = 1'b0;
    modelIo  = 8'h00;
    checkOutput("rerst_done", 8'(done), 8'd0);
    checkOutput("rerst_cpu_rst", 8'(cpu_rst), 8'd0);
    checkOutput("rerst_err", 8'(err), 8'(modelErr));
    checkOutput("rerst_io_out", io_out, modelIo);
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom_range(0, 254));
    loadImage(20, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom_range(0, 254));
    loadImage(DEPTH, 1'b1);
`ifdef MCPU_BOOT_CHKSUM_EN
    sendChecksum(1'b0);
    rst = 1'b0;
    tick();
    modelErr = 1'b0;
    rst = 1'b1;
    tick();
    loadImage(DEPTH, 1'b0);
    sendChecksum(1'b1);
`endif
    checkOutput("reload_err", 8'(err), 8'(modelErr));
    for (int i = 0; i < DEPTH; i++) readCheck("reload_word", i, model[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
